// File: rtl/gcd_requester.sv
// Initiator for the GCD responder's four-phase req/ack load protocol; pairs in, gcd plus cycle count out.
// Bypass pairs reach out_valid one cycle after accept; in_ready is low until the output handshake completes.
module gcd_requester #(
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         req,
    input  logic         ack,
    output logic [W-1:0] loadVal,
    input  logic [W-1:0] result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [15:0]  out_cycles,
    output logic         timeout
);

    localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] TO_VAL = WCW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, REL_A, LOAD_B, WAIT_RES, REL_RES, OUT
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   b_q, b_d;
    logic           req_q, req_d;
    logic [W-1:0]   loadval_q, loadval_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [15:0]    out_cycles_q, out_cycles_d;
    logic [15:0]    cyc_q, cyc_d, cyc_inc;
    logic [WCW-1:0] wait_q, wait_d, wait_inc;
    logic           timeout_q, timeout_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            b_q          <= '0;
            req_q        <= 1'b0;
            loadval_q    <= '0;
            out_data_q   <= '0;
            out_cycles_q <= '0;
            cyc_q        <= '0;
            wait_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            b_q          <= b_d;
            req_q        <= req_d;
            loadval_q    <= loadval_d;
            out_data_q   <= out_data_d;
            out_cycles_q <= out_cycles_d;
            cyc_q        <= cyc_d;
            wait_q       <= wait_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        b_d          = b_q;
        loadval_d    = loadval_q;
        out_data_d   = out_data_q;
        out_cycles_d = out_cycles_q;
        cyc_d        = cyc_q;
        timeout_d    = timeout_q;
        cyc_inc      = (&cyc_q) ? cyc_q : cyc_q + 16'd1;
        wait_inc     = (wait_q == TO_VAL) ? wait_q : wait_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    b_d   = in_b;
                    cyc_d = '0;
                    // The responder never terminates on a zero operand, so answer locally.
                    if (in_a == '0 || in_b == '0) begin
                        state_d      = OUT;
                        out_data_d   = in_a | in_b;
                        out_cycles_d = '0;
                    end else begin
                        state_d   = LOAD_A;
                        loadval_d = in_a;
                    end
                end
            end
            LOAD_A:   if (ack)  state_d = REL_A;
            REL_A: begin
                if (!ack) begin
                    state_d   = LOAD_B;
                    loadval_d = b_q;
                end
            end
            LOAD_B:   if (!ack) state_d = WAIT_RES;
            WAIT_RES: begin
                if (ack) begin
                    state_d      = REL_RES;
                    out_data_d   = result;
                    out_cycles_d = cyc_inc;
                end
            end
            REL_RES:  if (!ack) state_d = OUT;
            OUT:      if (out_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (state_q inside {LOAD_A, REL_A, LOAD_B, WAIT_RES}) begin
            cyc_d = cyc_inc;
        end

        req_d  = (state_d inside {LOAD_A, LOAD_B, WAIT_RES});
        wait_d = (state_d != state_q) ? '0 : wait_inc;

        // Flag only; the FSM keeps waiting for the responder.
        if (TIMEOUT != 0 && state_d == state_q &&
            (state_q inside {LOAD_A, REL_A, WAIT_RES, REL_RES}) && wait_inc == TO_VAL) begin
            timeout_d = 1'b1;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == OUT);
    assign req        = req_q;
    assign loadVal    = loadval_q;
    assign out_data   = out_data_q;
    assign out_cycles = out_cycles_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Initiator end of the four-phase req/ack operand-load protocol used by the team's GCD responder. Accepts operand pairs on a valid/ready input stream, loads them into the responder one at a time over the shared `loadVal` bus, and collects the result. Returns the result on a valid/ready output stream, together with a cycle count for the transaction. Sits between a stream producer/consumer and one GCD responder instance.

## Interface
- `W`, 32, operand/result width.
- `TIMEOUT`, 1024, max cycles to wait for any single ack edge before flagging; 0 disables.
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: pair accepted when `in_valid && in_ready`.
- `in_a`, `in_b` in W: operands.
- `req` out 1: protocol request to responder.
- `ack` in 1: protocol acknowledge from responder.
- `loadVal` out W: operand bus to responder.
- `result` in W: responder result, valid while `ack` is high in result phase.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`.
- `out_data` out W: GCD result.
- `out_cycles` out 16: cycles from first `req` rise to result-ack seen; saturates at 0xFFFF; 0 for bypassed pairs.
- `timeout` out 1: sticky flag; cleared only by reset.

## Operation
- States: IDLE, LOAD_A, REL_A, LOAD_B, WAIT_RES, REL_RES, OUT.
- IDLE: `in_ready=1`. On accept, latch `in_a`/`in_b`.
  - Either operand zero: skip the responder. Go to OUT with `out_data = a|b`, i.e. gcd(x,0)=x and gcd(0,0)=0. The responder never terminates on zero operands.
  - Otherwise go to LOAD_A with `loadVal=a`.
- LOAD_A: `req=1`, `loadVal=a`. Move to REL_A when `ack=1`.
- REL_A: `req=0`, `loadVal=a`. Move to LOAD_B only when `ack=0`. `req` must never rise while `ack` is still high.
- LOAD_B: `req=1`, `loadVal=b`. Move to WAIT_RES on the first cycle `ack=0` is seen with `req` high, i.e. the responder has latched b.
- WAIT_RES: `req=1`. When `ack=1`, capture `result` into `out_data`, then go to REL_RES.
- REL_RES: `req=0`. When `ack=0`, go to OUT. Returning the responder to its idle state before output keeps back-to-back pairs safe.
- OUT: `out_valid=1`. On `out_ready`, go to IDLE.
- `loadVal` is registered. It is updated on the same edge that raises `req`, and held stable for the whole time `req` is high plus the release phase.
- `out_cycles` counter: clears on accept, increments every cycle in LOAD_A through WAIT_RES, saturates, and is captured alongside `out_data`.
- Per-edge wait counter: reloads on every state change. In LOAD_A, REL_A, WAIT_RES, REL_RES, reaching TIMEOUT cycles sets `timeout=1`. The FSM keeps waiting; the flag is not auto-recovered.

## Timing
- Reset values: `req=0`, `loadVal=0`, `out_valid=0`, `out_data=0`, `out_cycles=0`, `timeout=0`, state IDLE. `in_ready=1` on the first cycle after reset deasserts.
- Reset mid-transaction: `req` drops at the next edge and buffered data is discarded. The system resets the responder in the same cycle.
- Accept at edge N: `req=1` and `loadVal=a` visible after N+1.
- Minimum handshake: each ack edge costs at least 1 cycle of detection.
- Bypass path: accept at N, `out_valid=1` after N+1.
- `in_ready=0` in every state except IDLE, so there is no overlap between transactions.
- `out_valid` and `out_data` hold stable until accepted.
- Back-to-back: `in_ready=1` on the cycle after the OUT handshake.

## Test plan
- Pair (48,18) against the responder, `out_ready=1`.
  - `out_data=6`, `out_valid` for one cycle, `timeout=0`.
  - `req` shows exactly two low-high-low pulse pairs: one rise for a, one rise continuing through b/result.
- Pair (0,7) and pair (0,0).
  - `out_data=7` and `out_data=0`.
  - `req` never asserts; `out_valid` one cycle after accept; `out_cycles=0`.
- Pair (35,14) with `out_ready=0` for 10 cycles.
  - `out_data=7` stays stable throughout and `in_ready=0`.
  - Releasing `out_ready` returns to IDLE on the next cycle.
- Four back-to-back pairs (12,8),(17,5),(100,75),(9,9) with `in_valid` held high.
  - Outputs 4,1,25,9 in order.
  - Protocol checker confirms no `req` rise while `ack=1`, and `loadVal` stable while `req=1`.
- `ack` tied 0, TIMEOUT=16, pair (6,4).
  - `req=1` stays high and `timeout` rises exactly 16 cycles after `req` rises.
  - `timeout` stays high until reset.
- Reset asserted while in WAIT_RES of pair (1000,3), then pair (21,6) issued.
  - Next cycle: `req=0`, `out_valid=0`.
  - The second pair yields 3 with correct `out_cycles`.
